branch_resolve_unit: RTL and testbench

EX-stage companion to the IF-stage branch target buffer.
- Compares the prediction carried down the pipeline with the actual branch outcome.
- On mismatch, raises a one-cycle registered flush with the correct redirect PC.
- Queues BTB write-back updates through a valid/ready FIFO, so that BTB fill and correction happen only here, never inside the lookup path.

---
 rtl/branch_resolve_unit.sv | 125 ++++++++++++
 tb/tb_branch_resolve_unit.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolution: mispredict detection, registered flush/redirect and a BTB update FIFO.
// Optional statistics counters are built only when BRU_STATS_EN is defined.
module branch_resolve_unit #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned QDEPTH = 4,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    input  logic              ex_stall,
    input  logic [ADDR_W-1:0] ex_pc,
    input  logic              ex_pred_taken,
    input  logic [ADDR_W-1:0] ex_pred_target,
    input  logic              ex_taken,
    input  logic [ADDR_W-1:0] ex_target,
    output logic              flush_o,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic              upd_valid,
    input  logic              upd_ready,
    output logic [ADDR_W-1:0] upd_pc,
    output logic [ADDR_W-1:0] upd_target,
    output logic              upd_taken,
    output logic [CNT_W-1:0]  branch_cnt,
    output logic [CNT_W-1:0]  mispred_cnt,
    output logic [CNT_W-1:0]  drop_cnt
);

    localparam int unsigned PtrW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int unsigned OccW = $clog2(QDEPTH + 1);

    logic              flush_q;
    logic [ADDR_W-1:0] redirect_q, redirect_d;

    logic [ADDR_W-1:0] fifo_pc     [QDEPTH];
    logic [ADDR_W-1:0] fifo_target [QDEPTH];
    logic              fifo_taken  [QDEPTH];
    logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [OccW-1:0]   occ_q, occ_d;

    logic resolve, mispred;
    logic full, empty, push, pop;

    // The flush cycle is the shadow cycle: whatever sits in EX is wrong-path.
    assign resolve = ex_valid & ~ex_stall & ~flush_q;
    assign mispred = resolve & ((ex_pred_taken != ex_taken) |
                                (ex_taken & (ex_pred_target != ex_target)));

    assign full  = (occ_q == OccW'(QDEPTH));
    assign empty = (occ_q == '0);
    assign pop   = ~empty & upd_ready;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is not lost.
    assign push  = mispred & (~full | pop);

    always_comb begin
        redirect_d = redirect_q;
        if (mispred) begin
            redirect_d = ex_taken ? ex_target : (ex_pc + ADDR_W'(4));
        end
    end

    always_comb begin
        occ_d = occ_q + OccW'(push) - OccW'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush_q    <= 1'b0;
            redirect_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
        end else begin
            flush_q    <= mispred;
            redirect_q <= redirect_d;
            occ_q      <= occ_d;
            if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc[wr_ptr_q]     <= ex_pc;
            fifo_target[wr_ptr_q] <= ex_target;
            fifo_taken[wr_ptr_q]  <= ex_taken;
        end
    end

    assign flush_o     = flush_q;
    assign redirect_pc = redirect_q;
    assign upd_valid   = ~empty;
    assign upd_pc      = fifo_pc[rd_ptr_q];
    assign upd_target  = fifo_target[rd_ptr_q];
    assign upd_taken   = fifo_taken[rd_ptr_q];

`ifdef BRU_STATS_EN
    logic             drop;
    logic [CNT_W-1:0] branch_q, mispred_q, drop_q;

    assign drop = mispred & full & ~pop;

    // Saturating counters: hold at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_q  <= '0;
            mispred_q <= '0;
            drop_q    <= '0;
        end else begin
            if (resolve && (branch_q != '1))  branch_q  <= branch_q + CNT_W'(1);
            if (mispred && (mispred_q != '1)) mispred_q <= mispred_q + CNT_W'(1);
            if (drop && (drop_q != '1))       drop_q    <= drop_q + CNT_W'(1);
        end
    end

    assign branch_cnt  = branch_q;
    assign mispred_cnt = mispred_q;
    assign drop_cnt    = drop_q;
`else
    assign branch_cnt  = '0;
    assign mispred_cnt = '0;
    assign drop_cnt    = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: directed vector table, hand sequences, and random stimulus
// checked against a queue-based reference model. Honours BRU_STATS_EN for counter expectations.
module tb_branch_resolve_unit;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned QDEPTH = 4;
    localparam int unsigned CNT_W  = 32;
`ifdef BRU_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif
    localparam longint CNT_MAX = (64'd1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              ex_valid = 1'b0, ex_stall = 1'b0, ex_pred_taken = 1'b0, ex_taken = 1'b0;
    logic [ADDR_W-1:0] ex_pc = '0, ex_pred_target = '0, ex_target = '0;
    logic              upd_ready = 1'b0;
    logic              flush_o, upd_valid, upd_taken;
    logic [ADDR_W-1:0] redirect_pc, upd_pc, upd_target;
    logic [CNT_W-1:0]  branch_cnt, mispred_cnt, drop_cnt;

    branch_resolve_unit #(.ADDR_W(ADDR_W), .QDEPTH(QDEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid(ex_valid), .ex_stall(ex_stall), .ex_pc(ex_pc),
        .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
        .ex_taken(ex_taken), .ex_target(ex_target),
        .flush_o(flush_o), .redirect_pc(redirect_pc),
        .upd_valid(upd_valid), .upd_ready(upd_ready),
        .upd_pc(upd_pc), .upd_target(upd_target), .upd_taken(upd_taken),
        .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] pc;
        logic [ADDR_W-1:0] target;
        logic              taken;
    } upd_t;

    typedef struct {
        logic v, s, r, pt, t;
        logic [ADDR_W-1:0] pc, ptg, tg;
        logic exp_flush;
        logic [ADDR_W-1:0] exp_redirect;
        logic exp_uv;
        logic [ADDR_W-1:0] exp_upc, exp_utgt;
        logic exp_utk;
        longint exp_bc, exp_mc;
    } vec_t;

    // Reference model state
    upd_t              mq[$];
    logic              m_flush;
    logic [ADDR_W-1:0] m_redirect;
    longint            m_bc, m_mc, m_dc;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic longint cnt_exp(input longint v);
        return STATS ? v : 0;
    endfunction

    task automatic check_model(input string tag);
        check({tag, ".flush"}, 64'(flush_o), 64'(m_flush));
        check({tag, ".redirect"}, 64'(redirect_pc), 64'(m_redirect));
        check({tag, ".upd_valid"}, 64'(upd_valid), 64'(mq.size() != 0));
        if (mq.size() != 0) begin
            check({tag, ".upd_pc"}, 64'(upd_pc), 64'(mq[0].pc));
            check({tag, ".upd_target"}, 64'(upd_target), 64'(mq[0].target));
            check({tag, ".upd_taken"}, 64'(upd_taken), 64'(mq[0].taken));
        end
        check({tag, ".branch_cnt"}, 64'(branch_cnt), 64'(cnt_exp(m_bc)));
        check({tag, ".mispred_cnt"}, 64'(mispred_cnt), 64'(cnt_exp(m_mc)));
        check({tag, ".drop_cnt"}, 64'(drop_cnt), 64'(cnt_exp(m_dc)));
    endtask

    task automatic model_reset();
        mq.delete();
        m_flush = 1'b0;
        m_redirect = '0;
        m_bc = 0;
        m_mc = 0;
        m_dc = 0;
    endtask

    // Drive one cycle of inputs, advance the model from the specification's rules, compare.
    task automatic step(input string tag, input logic v, input logic s, input logic r,
                        input logic [ADDR_W-1:0] pc, input logic pt,
                        input logic [ADDR_W-1:0] ptg, input logic t,
                        input logic [ADDR_W-1:0] tg);
        bit   res, mp, pop;
        upd_t e;
        ex_valid = v; ex_stall = s; upd_ready = r; ex_pc = pc;
        ex_pred_taken = pt; ex_pred_target = ptg; ex_taken = t; ex_target = tg;
        res = v && !s && !m_flush;
        mp  = res && ((pt != t) || (t && ptg != tg));
        pop = (mq.size() != 0) && r;
        if (pop) void'(mq.pop_front());
        if (mp) begin
            if (mq.size() < QDEPTH) begin
                e.pc = pc; e.target = tg; e.taken = t;
                mq.push_back(e);
            end else if (m_dc < CNT_MAX) m_dc++;
        end
        m_flush = mp;
        if (mp) m_redirect = t ? tg : pc + 32'd4;
        if (res && m_bc < CNT_MAX) m_bc++;
        if (mp && m_mc < CNT_MAX) m_mc++;
        @(posedge clk);
        #1;
        check_model(tag);
    endtask

    task automatic idle(input string tag, input logic r);
        step(tag, 1'b0, 1'b0, r, '0, 1'b0, '0, 1'b0, '0);
    endtask

    task automatic do_reset();
        ex_valid = 1'b0; ex_stall = 1'b0; upd_ready = 1'b0;
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        check_model("reset");
        rst_n = 1'b1;
    endtask

    function automatic vec_t mk(input logic v, s, r, input logic [ADDR_W-1:0] pc,
                                input logic pt, input logic [ADDR_W-1:0] ptg,
                                input logic t, input logic [ADDR_W-1:0] tg,
                                input logic ef, input logic [ADDR_W-1:0] er,
                                input logic euv, input logic [ADDR_W-1:0] eupc, eutgt,
                                input logic eutk, input longint ebc, emc);
        vec_t x;
        x.v = v; x.s = s; x.r = r; x.pc = pc; x.pt = pt; x.ptg = ptg; x.t = t; x.tg = tg;
        x.exp_flush = ef; x.exp_redirect = er; x.exp_uv = euv;
        x.exp_upc = eupc; x.exp_utgt = eutgt; x.exp_utk = eutk;
        x.exp_bc = ebc; x.exp_mc = emc;
        return x;
    endfunction

    vec_t tbl[10];

    initial begin
        // Expected outputs observed just after the edge that consumes each row's inputs.
        tbl[0] = mk(1,0,0, 32'h100, 1, 32'h200, 1, 32'h200,  0, 32'h0,   0, 0, 0, 0, 1, 0);
        tbl[1] = mk(1,0,0, 32'h100, 0, 32'h0,   1, 32'h180,  1, 32'h180, 1, 32'h100, 32'h180, 1, 2, 1);
        tbl[2] = mk(0,0,0, 32'h0,   0, 32'h0,   0, 32'h0,    0, 32'h180, 1, 32'h100, 32'h180, 1, 2, 1);
        tbl[3] = mk(0,0,1, 32'h0,   0, 32'h0,   0, 32'h0,    0, 32'h180, 0, 0, 0, 0, 2, 1);
        tbl[4] = mk(1,0,0, 32'h300, 1, 32'h200, 1, 32'h240,  1, 32'h240, 1, 32'h300, 32'h240, 1, 3, 2);
        tbl[5] = mk(1,0,0, 32'h400, 0, 32'h0,   1, 32'h500,  0, 32'h240, 1, 32'h300, 32'h240, 1, 3, 2);
        tbl[6] = mk(0,0,1, 32'h0,   0, 32'h0,   0, 32'h0,    0, 32'h240, 0, 0, 0, 0, 3, 2);
        tbl[7] = mk(1,0,0, 32'hFFFFFFFC, 1, 32'h1000, 0, 32'h0,
                    1, 32'h0, 1, 32'hFFFFFFFC, 32'h0, 0, 4, 3);
        tbl[8] = mk(0,0,1, 32'h0,   0, 32'h0,   0, 32'h0,    0, 32'h0,   0, 0, 0, 0, 4, 3);
        tbl[9] = mk(1,1,0, 32'h500, 0, 32'h0,   1, 32'h600,  0, 32'h0,   0, 0, 0, 0, 4, 3);

        model_reset();
        do_reset();
        check("reset.upd_valid", 64'(upd_valid), 64'd0);
        check("reset.flush", 64'(flush_o), 64'd0);

        for (int i = 0; i < 10; i++) begin
            step($sformatf("vec%0d", i), tbl[i].v, tbl[i].s, tbl[i].r, tbl[i].pc, tbl[i].pt,
                 tbl[i].ptg, tbl[i].t, tbl[i].tg);
            check($sformatf("vec%0d.flush", i), 64'(flush_o), 64'(tbl[i].exp_flush));
            check($sformatf("vec%0d.redirect", i), 64'(redirect_pc), 64'(tbl[i].exp_redirect));
            check($sformatf("vec%0d.upd_valid", i), 64'(upd_valid), 64'(tbl[i].exp_uv));
            if (tbl[i].exp_uv) begin
                check($sformatf("vec%0d.upd_pc", i), 64'(upd_pc), 64'(tbl[i].exp_upc));
                check($sformatf("vec%0d.upd_target", i), 64'(upd_target), 64'(tbl[i].exp_utgt));
                check($sformatf("vec%0d.upd_taken", i), 64'(upd_taken), 64'(tbl[i].exp_utk));
            end
            check($sformatf("vec%0d.branch_cnt", i), 64'(branch_cnt), 64'(cnt_exp(tbl[i].exp_bc)));
            check($sformatf("vec%0d.mispred_cnt", i), 64'(mispred_cnt), 64'(cnt_exp(tbl[i].exp_mc)));
        end

        // Backpressure: five separated mispredicts into a depth-4 FIFO.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step("bp.push", 1'b1, 1'b0, 1'b0, 32'h1000 + 32'(16 * i), 1'b0, '0, 1'b1,
                 32'h2000 + 32'(16 * i));
            idle("bp.gap", 1'b0);
        end
        check("bp.drop_cnt", 64'(drop_cnt), 64'(cnt_exp(1)));
        check("bp.mispred_cnt", 64'(mispred_cnt), 64'(cnt_exp(5)));
        for (int i = 0; i < 4; i++) begin
            check($sformatf("bp.head%0d.valid", i), 64'(upd_valid), 64'd1);
            check($sformatf("bp.head%0d.pc", i), 64'(upd_pc), 64'(32'h1000 + 32'(16 * i)));
            check($sformatf("bp.head%0d.target", i), 64'(upd_target), 64'(32'h2000 + 32'(16 * i)));
            idle("bp.pop", 1'b1);
        end
        check("bp.drained", 64'(upd_valid), 64'd0);

        // Stall suppression, then asynchronous reset with two queued entries.
        do_reset();
        step("st.stall", 1'b1, 1'b1, 1'b0, 32'h700, 1'b0, '0, 1'b1, 32'h740);
        check("st.no_flush", 64'(flush_o), 64'd0);
        idle("st.idle", 1'b0);
        check("st.no_flush2", 64'(flush_o), 64'd0);
        step("st.m0", 1'b1, 1'b0, 1'b0, 32'h800, 1'b0, '0, 1'b1, 32'h840);
        idle("st.gap", 1'b0);
        step("st.m1", 1'b1, 1'b0, 1'b0, 32'h900, 1'b1, 32'h940, 1'b0, 32'h0);
        idle("st.gap", 1'b0);
        check("st.queued", 64'(upd_valid), 64'd1);
        rst_n = 1'b0;
        model_reset();
        #2;
        check("arst.upd_valid", 64'(upd_valid), 64'd0);
        check("arst.flush", 64'(flush_o), 64'd0);
        check("arst.branch_cnt", 64'(branch_cnt), 64'd0);
        check("arst.mispred_cnt", 64'(mispred_cnt), 64'd0);
        check("arst.drop_cnt", 64'(drop_cnt), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) idle("arst.after", 1'b1);
        check("arst.still_empty", 64'(upd_valid), 64'd0);

        // Random stimulus against the model.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            logic v, s, r, pt, t;
            logic [ADDR_W-1:0] pc, ptg, tg;
            v   = ($urandom_range(0, 9) < 6);
            s   = ($urandom_range(0, 4) == 0);
            r   = ($urandom_range(0, 9) < 3);
            pc  = ($urandom_range(0, 15) == 0) ? 32'hFFFFFFFC : 32'($urandom_range(0, 255)) << 2;
            pt  = 1'($urandom);
            t   = 1'($urandom);
            ptg = 32'h1000 + 32'($urandom_range(0, 1)) * 4;
            tg  = 32'h1000 + 32'($urandom_range(0, 1)) * 4;
            step("rand", v, s, r, pc, pt, ptg, t, tg);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
